// File: rtl/switch_allocator.sv
// ============================================================================
//  Module   : switch_allocator
//  Purpose  : Wormhole output-port allocator. Each output has its own
//             round-robin arbiter and holds a lock on the winning input
//             until that packet's tail flit has been granted.
//  Options  : `define SA_GRANT_CNT_EN adds saturating per-output flit counters
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module switch_allocator #(
  parameter  int N_PORTS = 5,
  parameter  int CNT_W   = 16,
  localparam int SEL_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [0:N_PORTS-1][0:N_PORTS-1]   i_req,
  input  logic [0:N_PORTS-1]                i_tail,
  input  logic [0:N_PORTS-1]                i_out_ready,
  output logic [0:N_PORTS-1][0:N_PORTS-1]   o_grant,
  output logic [0:N_PORTS-1]                o_in_grant,
  output logic [0:N_PORTS-1]                o_out_valid,
  output logic [0:N_PORTS-1][SEL_W-1:0]     o_xbar_sel,
  output logic [0:N_PORTS-1][CNT_W-1:0]     o_grant_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q [N_PORTS];
  state_e           state_d [N_PORTS];
  logic [SEL_W-1:0] owner_q [N_PORTS];
  logic [SEL_W-1:0] owner_d [N_PORTS];
  logic [SEL_W-1:0] ptr_q   [N_PORTS];
  logic [SEL_W-1:0] ptr_d   [N_PORTS];

  logic [0:N_PORTS-1][0:N_PORTS-1] w_req_eff;
  logic [0:N_PORTS-1]              w_win_vld;
  logic [SEL_W-1:0]                w_win [N_PORTS];

  // A malformed multi-hot request row keeps only its lowest-index output.
  always_comb begin
    logic w_seen;
    w_req_eff = '0;
    w_seen    = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_seen = 1'b0;
      for (int o = 0; o < N_PORTS; o++) begin
        w_req_eff[i][o] = i_req[i][o] && !w_seen;
        w_seen          = w_seen | i_req[i][o];
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < N_PORTS; o++) begin
      w_win_vld[o] = 1'b0;
      w_win[o]     = '0;
      if (!i_reset && i_out_ready[o]) begin
        if (state_q[o] == ST_LOCKED) begin
          if (w_req_eff[owner_q[o]][o]) begin
            w_win_vld[o] = 1'b1;
            w_win[o]     = owner_q[o];
          end
        end else begin
          // Scan downwards so the candidate closest to the pointer is written last.
          for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx = int'(ptr_q[o]) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (w_req_eff[idx][o]) begin
              w_win_vld[o] = 1'b1;
              w_win[o]     = SEL_W'(idx);
            end
          end
        end
      end
    end
  end

  always_comb begin
    o_grant    = '0;
    o_in_grant = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      o_out_valid[o] = w_win_vld[o];
      o_xbar_sel[o]  = w_win_vld[o] ? w_win[o] : '0;
      for (int i = 0; i < N_PORTS; i++) begin
        o_grant[i][o] = w_win_vld[o] && (w_win[o] == SEL_W'(i));
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      o_in_grant[i] = |o_grant[i];
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (w_win_vld[o]) begin
        if (i_tail[w_win[o]]) begin
          state_d[o] = ST_IDLE;
          ptr_d[o]   = (w_win[o] == SEL_W'(N_PORTS - 1)) ? '0 : w_win[o] + 1'b1;
        end else begin
          state_d[o] = ST_LOCKED;
          owner_d[o] = w_win[o];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int o = 0; o < N_PORTS; o++) begin
      if (i_reset) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

`ifdef SA_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_PORTS];

  always_ff @(posedge i_clk) begin
    for (int o = 0; o < N_PORTS; o++) begin
      if (i_reset) begin
        cnt_q[o] <= '0;
      end else if (o_out_valid[o] && (cnt_q[o] != {CNT_W{1'b1}})) begin
        cnt_q[o] <= cnt_q[o] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      o_grant_cnt[o] = cnt_q[o];
    end
  end
`else
  assign o_grant_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_allocator.sv
// ============================================================================
//  Module   : tb_switch_allocator
//  Purpose  : Self-checking bench for switch_allocator (5 ports, CNT_W=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_switch_allocator;

  localparam int NP = 5;
  localparam int CW = 4;

  logic                  clk;
  logic                  i_reset;
  logic [0:NP-1][0:NP-1] i_req;
  logic [0:NP-1]         i_tail;
  logic [0:NP-1]         i_out_ready;
  logic [0:NP-1][0:NP-1] o_grant;
  logic [0:NP-1]         o_in_grant;
  logic [0:NP-1]         o_out_valid;
  logic [0:NP-1][2:0]    o_xbar_sel;
  logic [0:NP-1][CW-1:0] o_grant_cnt;

  switch_allocator #(.N_PORTS(NP), .CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_tail      (i_tail),
    .i_out_ready (i_out_ready),
    .o_grant     (o_grant),
    .o_in_grant  (o_in_grant),
    .o_out_valid (o_out_valid),
    .o_xbar_sel  (o_xbar_sel),
    .o_grant_cnt (o_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: owner -1 means the output is free.
  int m_owner [NP];
  int m_ptr   [NP];
  int m_cnt   [NP];

`ifdef SA_GRANT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:NP-1][0:NP-1] rq(input int i, input logic [0:NP-1] v);
    logic [0:NP-1][0:NP-1] r;
    r    = '0;
    r[i] = v;
    return r;
  endfunction

  // One cycle: drive, check at the falling edge, advance reference, step past the rising edge.
  task automatic step(input logic [0:NP-1][0:NP-1] req, input logic [0:NP-1] tail,
                      input logic [0:NP-1] ready, input bit rst,
                      output logic [0:NP-1][0:NP-1] g_seen);
    int                    want [NP];
    int                    win  [NP];
    logic [0:NP-1][0:NP-1] e_grant;
    logic [0:NP-1]         e_in, e_vld;
    logic [0:NP-1][2:0]    e_sel;
    logic [0:NP-1][CW-1:0] e_cnt;
    i_req = req; i_tail = tail; i_out_ready = ready; i_reset = rst;
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      want[i] = -1;
      for (int o = NP - 1; o >= 0; o--) if (req[i][o]) want[i] = o;
    end
    e_grant = '0; e_in = '0; e_vld = '0; e_sel = '0;
    for (int o = 0; o < NP; o++) begin
      win[o] = -1;
      if (!rst && ready[o]) begin
        if (m_owner[o] >= 0) begin
          if (want[m_owner[o]] == o) win[o] = m_owner[o];
        end else begin
          for (int k = 0; k < NP; k++)
            if (win[o] < 0 && want[(m_ptr[o] + k) % NP] == o) win[o] = (m_ptr[o] + k) % NP;
        end
      end
      if (win[o] >= 0) begin
        e_grant[win[o]][o] = 1'b1;
        e_in[win[o]]       = 1'b1;
        e_vld[o]           = 1'b1;
        e_sel[o]           = 3'(win[o]);
      end
      e_cnt[o] = CW'(m_cnt[o]);
    end
    g_seen = o_grant;
    check("grant",     32'(o_grant),     32'(e_grant));
    check("in_grant",  32'(o_in_grant),  32'(e_in));
    check("out_valid", 32'(o_out_valid), 32'(e_vld));
    check("xbar_sel",  32'(o_xbar_sel),  32'(e_sel));
    check("grant_cnt", 32'(o_grant_cnt), 32'(e_cnt));
    for (int o = 0; o < NP; o++) begin
      if (rst) begin
        m_owner[o] = -1; m_ptr[o] = 0; m_cnt[o] = 0;
      end else if (win[o] >= 0) begin
        if (tail[win[o]]) begin
          m_owner[o] = -1;
          m_ptr[o]   = (win[o] + 1) % NP;
        end else begin
          m_owner[o] = win[o];
        end
        if (CNT_ON && m_cnt[o] < (1 << CW) - 1) m_cnt[o]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [0:NP-1][0:NP-1] req;
    logic [0:NP-1]         tail;
    logic [0:NP-1]         ready;
    bit                    rst;
    logic [0:NP-1][0:NP-1] exp_grant;
  } vec_t;

  initial begin
    vec_t                  tbl [$];
    logic [0:NP-1][0:NP-1] g;
    logic [0:NP-1][0:NP-1] none;
    logic [0:NP-1][0:NP-1] rr;
    logic [0:NP-1]         tt, yy;

    none = '0;
    for (int o = 0; o < NP; o++) begin m_owner[o] = -1; m_ptr[o] = 0; m_cnt[o] = 0; end
    i_reset = 1'b1; i_req = '0; i_tail = '0; i_out_ready = '0;
    @(posedge clk);
    #1;

    // Reset, then single-flit n->e, then ptr[e]=2 makes input 3 beat input 0.
    tbl.push_back('{rq(1,5'b00100), 5'b11111, 5'b11111, 1'b1, none});
    tbl.push_back('{rq(1,5'b00100), 5'b01000, 5'b11111, 1'b0, rq(1,5'b00100)});
    tbl.push_back('{rq(0,5'b00100)|rq(3,5'b00100), 5'b11111, 5'b11111, 1'b0, rq(3,5'b00100)});
    // Three single-flit requesters on e from ptr=0: order 0,3,4,0,3.
    tbl.push_back('{none, 5'b00000, 5'b11111, 1'b1, none});
    for (int c = 0; c < 5; c++) begin
      int w;
      w = (c % 3 == 0) ? 0 : (c % 3 == 1) ? 3 : 4;
      tbl.push_back('{rq(0,5'b00100)|rq(3,5'b00100)|rq(4,5'b00100), 5'b11111, 5'b11111, 1'b0,
                      rq(w,5'b00100)});
    end
    // Four-flit packet from input 1 to s holds off input 2 until cycle 4.
    tbl.push_back('{none, 5'b00000, 5'b11111, 1'b1, none});
    for (int c = 0; c < 4; c++)
      tbl.push_back('{rq(1,5'b00010)|rq(2,5'b00010), (c == 3) ? 5'b01100 : 5'b00100, 5'b11111, 1'b0,
                      rq(1,5'b00010)});
    tbl.push_back('{rq(2,5'b00010), 5'b00100, 5'b11111, 1'b0, rq(2,5'b00010)});
    // Multi-hot row: only the lowest-index output (c) is honoured.
    tbl.push_back('{rq(4,5'b10011), 5'b00001, 5'b11111, 1'b0, rq(4,5'b10000)});

    foreach (tbl[v]) begin
      step(tbl[v].req, tbl[v].tail, tbl[v].ready, tbl[v].rst, g);
      check($sformatf("tbl%0d", v), 32'(g), 32'(tbl[v].exp_grant));
    end

    // Backpressure mid-packet: owner 3 keeps n while input 0 waits.
    step(none, 5'b00000, 5'b11111, 1'b1, g);
    step(rq(3,5'b01000), 5'b00000, 5'b11111, 1'b0, g);
    check("bp_lock", 32'(g), 32'(rq(3,5'b01000)));
    for (int c = 0; c < 3; c++) begin
      step(rq(0,5'b01000)|rq(3,5'b01000), 5'b10000, 5'b10111, 1'b0, g);
      check("bp_stall", 32'(g), 32'(none));
    end
    step(rq(0,5'b01000)|rq(3,5'b01000), 5'b10000, 5'b11111, 1'b0, g);
    check("bp_resume", 32'(g), 32'(rq(3,5'b01000)));

    // Reset while w is locked by input 3 drops the lock.
    step(rq(3,5'b00001), 5'b00000, 5'b11111, 1'b0, g);
    step(rq(3,5'b00001), 5'b00000, 5'b11111, 1'b0, g);
    check("rst_pre", 32'(g), 32'(rq(3,5'b00001)));
    step(rq(0,5'b00001)|rq(3,5'b00001), 5'b00000, 5'b11111, 1'b1, g);
    check("rst_cycle", 32'(g), 32'(none));
    step(rq(0,5'b00001)|rq(3,5'b00001), 5'b10000, 5'b11111, 1'b0, g);
    check("rst_after", 32'(g), 32'(rq(0,5'b00001)));

    // Twenty single flits to c: counter saturates at 15 when enabled.
    step(none, 5'b00000, 5'b11111, 1'b1, g);
    for (int c = 0; c < 20; c++) step(rq(1,5'b10000), 5'b01000, 5'b11111, 1'b0, g);
    check("cnt_sat", 32'(o_grant_cnt[0]), CNT_ON ? 32'd15 : 32'd0);

    // Random traffic against the reference model.
    step(none, 5'b00000, 5'b11111, 1'b1, g);
    for (int c = 0; c < 400; c++) begin
      rr = '0;
      for (int i = 0; i < NP; i++) begin
        int r;
        r = $urandom_range(0, 7);
        if (r < 5)       rr[i][r] = 1'b1;
        else if (r == 6) rr[i] = 5'($urandom);
      end
      tt = 5'($urandom);
      for (int o = 0; o < NP; o++) yy[o] = ($urandom_range(0, 3) != 0);
      step(rr, tt, yy, ($urandom_range(0, 59) == 0), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
